mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares the single unified instruction/data memory between the multicycle CPU (fetch and load/store through its Controller/Datapath) and an external loader/debug master. One transaction is in flight at a time. Round-robin arbitration applies unless the external master holds a lock. The block hides memory read latency behind a request/grant/done handshake and drives `cpu_stall` so the CPU controller FSM holds its state until its access completes.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MEM_LAT`, 1, memory read latency in cycles; legal range 1..4.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU access request; held high until `cpu_gnt`.
- `cpu_we`  in  1  CPU write enable (1 = store, 0 = fetch/load).
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_gnt`  out  1  one-cycle pulse; CPU request accepted.
- `cpu_done`  out  1  one-cycle pulse; CPU access complete.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_done` is high for a read.
- `cpu_stall`  out  1  combinational: `cpu_req` OR CPU transaction outstanding, AND NOT `cpu_done`.
- `ext_req`, `ext_we`, `ext_addr`, `ext_wdata`, `ext_gnt`, `ext_done`, `ext_rdata`: same directions, widths and rules as the `cpu_*` ports, for the external master.
- `ext_lock`  in  1  while high, new CPU requests are not granted.
- `mem_en`  out  1  memory access strobe, one cycle per transaction.
- `mem_we`  out  1  memory write; high only together with `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after the `mem_en` cycle.

## Operation
- States:
  - IDLE: no transaction; arbitrate.
  - ISSUE: `mem_en` high, grant pulse.
  - WAIT: read latency count.
  - DONE: done pulse; arbitrate again.
- Arbitration occurs at an edge in IDLE or DONE.
  - Eligible requesters: `ext_req`, and `cpu_req` AND NOT `ext_lock`.
  - One eligible requester: grant it.
  - Both eligible: grant the requester not served last (`last_owner` register).
  - None eligible: go to IDLE.
- On a grant:
  - Latch `owner`, `we`, `addr` and `wdata`.
  - Go to ISSUE.
  - Update `last_owner`.
- ISSUE:
  - `mem_en`=1.
  - `mem_we`=latched `we`.
  - `mem_addr`/`mem_wdata` = latched values.
  - `<owner>_gnt`=1.
  - Next state: a write goes to DONE; a read goes to WAIT with counter = `MEM_LAT`-1. If `MEM_LAT`=1, the read goes directly to the capture step.
- WAIT: the counter decrements. At the edge ending cycle ISSUE+`MEM_LAT`, `mem_rdata` is captured into `<owner>_rdata`, and the state moves to DONE.
- DONE: `<owner>_done`=1 for one cycle; arbitration as above.
- Requester rules:
  - Deassert `req` before the edge ending the gnt cycle, unless a new access follows.
  - A `req` high at the DONE edge is a new request.
- `ext_lock` asserted mid-CPU-transaction: the CPU transaction completes normally; only new grants are blocked.
- `rdata` registers hold their last value until the next read for that owner completes.
- `mem_addr`/`mem_wdata` hold their latched values outside ISSUE.

## Timing
- Reset (`reset`=0 at an edge):
  - State IDLE; `last_owner`=EXT, so the CPU wins the first tie.
  - All outputs 0: gnt, done, rdata, `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`.
  - `cpu_stall` = `cpu_req`.
- Reset mid-transaction: the in-flight access is abandoned with no done pulse. A write already strobed may have reached memory.
- Latency from the request-sampling edge E:
  - gnt in cycle E+1.
  - Write done in cycle E+2.
  - Read done in cycle E+2+`MEM_LAT`.
- Throughput: back-to-back writes take one transaction per 2 cycles; reads take one per `MEM_LAT`+2.
- Simultaneous events:
  - Both requests at the same edge: round-robin decides.
  - Request arriving during ISSUE/WAIT: waits; it is sampled at the DONE edge.
- `cpu_stall` is high from the first cycle `cpu_req` is high through the cycle before `cpu_done`.

## Test plan
- Reset, then a CPU read with `cpu_addr`=0x0000_0010, `MEM_LAT`=1, memory returning 0x0051_0093 → `cpu_gnt` in cycle 1, `mem_en`=1 with `mem_addr`=0x10 in the same cycle, `cpu_done` with `cpu_rdata`=0x0051_0093 in cycle 3, `cpu_stall` low in cycle 3.
- External write of 0xDEAD_BEEF to 0x100 → `mem_we`=1 for exactly one cycle, `ext_done` one cycle later; a following CPU read of 0x100 returns 0xDEAD_BEEF.
- `cpu_req` and `ext_req` asserted together and held for 4 transactions → grants alternate CPU, EXT, CPU, EXT; there are never two transactions in flight.
- `ext_lock`=1 with both requesting → only EXT is served; `cpu_stall` stays high. Drop the lock → CPU granted at the next arbitration edge.
- `MEM_LAT`=3 read → `cpu_done` 5 cycles after the sampling edge, with the rdata captured from cycle ISSUE+3.
- `reset` pulled low during WAIT → no done pulse; all outputs 0 next cycle; a new request after release is served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between the CPU and an external loader/debug master.
// One transaction in flight; round-robin arbitration unless the external master holds the lock.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_done,
    output logic [DATA_W-1:0] ext_rdata,
    input  logic              ext_lock,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    // state | meaning
    // IDLE  | nothing in flight, arbitrate    ISSUE | mem_en + grant pulse
    // WAIT  | read latency count               DONE  | done pulse, arbitrate again

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    localparam int CNT_W = 2;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

    logic cpu_elig;
    logic ext_elig;
    logic grant_valid;
    logic grant_owner;

    assign cpu_elig    = cpu_req & ~ext_lock;
    assign ext_elig    = ext_req;
    assign grant_valid = cpu_elig | ext_elig;
    // On a tie the requester not served last wins; otherwise the only eligible one.
    assign grant_owner = (cpu_elig & ext_elig) ? ~last_owner_q : ext_elig;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        cpu_rdata_d  = cpu_rdata_q;
        ext_rdata_d  = ext_rdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (grant_valid) begin
                    state_d      = ST_ISSUE;
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    if (grant_owner == OWN_EXT) begin
                        we_d    = ext_we;
                        addr_d  = ext_addr;
                        wdata_d = ext_wdata;
                    end else begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_EXT) begin
                        ext_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_EXT;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_gnt   = mem_en & (owner_q == OWN_CPU);
    assign ext_gnt   = mem_en & (owner_q == OWN_EXT);
    assign cpu_done  = (state_q == ST_DONE) & (owner_q == OWN_CPU);
    assign ext_done  = (state_q == ST_DONE) & (owner_q == OWN_EXT);
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;

    // Stall covers the request phase and the outstanding phase, released in the done cycle.
    assign cpu_stall = (cpu_req | ((state_q != ST_IDLE) & (owner_q == OWN_CPU))) & ~cpu_done;

endmodule
